// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: time-multiplexed scan controller for common-anode seven-segment digits.
//   Drives one shared hex decoder (dig_val) and a one-hot digit enable (dig_en).
//   New display words arrive on a valid/ready handshake and are committed only at frame end.
//   Ports: clk, rst (async, active-high), load_valid/load_data/load_ready (word handshake),
//          blank_lz (leading-zero blanking), dig_val (nibble of the active digit),
//          dig_en (digit enables, polarity EN_ACTIVE_LOW), frame_start (first cycle of slot 0).
//   Optional macro HEX_SCAN_BLINK_EN adds blink_mask and BLINK_FRAMES for per-digit blinking.
module hex_scan_ctrl #(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter int DEAD_CYCLES   = 2,
    parameter int EN_ACTIVE_LOW = 1
`ifdef HEX_SCAN_BLINK_EN
    ,
    parameter int BLINK_FRAMES  = 32
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic                    load_ready,
    input  logic                    blank_lz,
`ifdef HEX_SCAN_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [3:0]              dig_val,
    output logic [NUM_DIGITS-1:0]   dig_en,
    output logic                    frame_start
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DEAD    = CW'(DEAD_CYCLES);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    typedef enum logic {IDLE, PENDING} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d, shadow_q, shadow_d;
    // Suppresses frame_start on the very first cycle after reset release.
    logic                    started_q;
    logic                    frame_end;
    logic [NUM_DIGITS-1:0]   zf, blk, blink, onehot;

    assign frame_end = (cnt_q == CNT_MAX) && (idx_q == IDX_MAX);

`ifdef HEX_SCAN_BLINK_EN
    localparam int FW = $clog2(2 * BLINK_FRAMES);
    localparam logic [FW-1:0] FRM_MAX  = FW'(2 * BLINK_FRAMES - 1);
    localparam logic [FW-1:0] FRM_HALF = FW'(BLINK_FRAMES);
    logic [FW-1:0] frm_q, frm_d;
    assign frm_d = frame_end ? ((frm_q == FRM_MAX) ? '0 : frm_q + 1'b1) : frm_q;
    assign blink = (frm_q >= FRM_HALF) ? blink_mask : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) frm_q <= '0;
        else     frm_q <= frm_d;
    end
`else
    assign blink = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            disp_q    <= '0;
            shadow_q  <= '0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            shadow_q  <= shadow_d;
            started_q <= 1'b1;
        end
    end

    always_comb begin
        cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        idx_d = (cnt_q != CNT_MAX) ? idx_q : ((idx_q == IDX_MAX) ? '0 : idx_q + 1'b1);
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        disp_d   = disp_q;
        if (state_q == IDLE) begin
            if (load_valid) begin
                shadow_d = load_data;
                state_d  = PENDING;
            end
        end else if (frame_end) begin
            disp_d  = shadow_q;
            state_d = IDLE;
        end
    end

    // zf[i]: nibbles i..NUM_DIGITS-1 of the committed word are all zero.
    always_comb begin
        zf = '0;
        zf[NUM_DIGITS-1] = disp_q[4*NUM_DIGITS-1 -: 4] == 4'h0;
        for (int i = NUM_DIGITS - 2; i >= 0; i--)
            zf[i] = zf[i+1] & (disp_q[4*i +: 4] == 4'h0);
        blk    = (blank_lz ? {zf[NUM_DIGITS-1:1], 1'b0} : '0) | blink;
        onehot = (cnt_q >= DEAD && !blk[idx_q]) ? NUM_DIGITS'(1) << idx_q : '0;
        dig_en = (EN_ACTIVE_LOW != 0) ? ~onehot : onehot;
    end

    assign dig_val     = disp_q[{idx_q, 2'b00} +: 4];
    assign load_ready  = state_q == IDLE;
    assign frame_start = started_q && cnt_q == '0 && idx_q == '0;
endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb_hex_scan_ctrl: directed self-checking bench for hex_scan_ctrl (4 digits, 4-cycle slots, 1 dead cycle).
module tb_hex_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0;
    logic        blank_lz = 1'b0;
    logic        load_ready, frame_start;
    logic [3:0]  dig_val, dig_en;
`ifdef HEX_SCAN_BLINK_EN
    logic [3:0]  bmask = 4'b0000;
`endif
    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    hex_scan_ctrl #(
        .NUM_DIGITS(4),
        .REFRESH_DIV(4),
        .DEAD_CYCLES(1),
        .EN_ACTIVE_LOW(1)
`ifdef HEX_SCAN_BLINK_EN
        ,
        .BLINK_FRAMES(2)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .load_valid(load_valid),
        .load_data(load_data),
        .load_ready(load_ready),
        .blank_lz(blank_lz),
`ifdef HEX_SCAN_BLINK_EN
        .blink_mask(bmask),
`endif
        .dig_val(dig_val),
        .dig_en(dig_en),
        .frame_start(frame_start)
    );

    // Expected active-low enable for cycle c after reset release, committed word d.
    function automatic logic [3:0] exp_en(input int c, input logic [15:0] d, input logic blz);
        int cn, ix;
        logic [15:0] sh;
        logic b;
        cn = c % 4;
        ix = (c / 4) % 4;
        sh = d >> (4 * ix);
        b  = blz && ix > 0 && sh == 16'h0;
`ifdef HEX_SCAN_BLINK_EN
        b  = b || (bmask[ix] && ((c / 16) % 4) >= 2);
`endif
        return (cn >= 1 && !b) ? ~(4'b0001 << ix) : 4'hF;
    endfunction

    function automatic logic [3:0] exp_val(input int c, input logic [15:0] d);
        return d[4*((c/4)%4) +: 4];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s at cyc %0d: observed %0h expected %0h", tag, cyc, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic slot_check(input string tag, input logic [15:0] d);
        check({tag, " en"}, 32'(dig_en), 32'(exp_en(cyc, d, blank_lz)));
        check({tag, " val"}, 32'(dig_val), 32'(exp_val(cyc, d)));
        check({tag, " fs"}, 32'(frame_start), 32'(cyc % 16 == 0 && cyc != 0));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0;
        check("rst en", 32'(dig_en), 32'hF);
        check("rst val", 32'(dig_val), 32'h0);
        check("rst rdy", 32'(load_ready), 32'h1);
        check("rst fs", 32'(frame_start), 32'h0);
        repeat (16) begin
            step();
            slot_check("scan", 16'h0);
        end
        step();
        load_valid = 1'b1;
        load_data  = 16'h12A4;
        check("rdy pre", 32'(load_ready), 32'h1);
        step();
        load_valid = 1'b0;
        while (cyc < 32) begin
            check("rdy pend", 32'(load_ready), 32'h0);
            slot_check("old", 16'h0);
            step();
        end
        check("rdy back", 32'(load_ready), 32'h1);
        check("commit val", 32'(dig_val), 32'h4);
        while (cyc < 48) begin
            slot_check("w12A4", 16'h12A4);
            step();
        end
        load_valid = 1'b1;
        load_data  = 16'h0070;
        step();
        load_data  = 16'h0007;
        while (cyc < 64) begin
            check("hold rdy", 32'(load_ready), 32'h0);
            slot_check("w12A4 hold", 16'h12A4);
            step();
        end
        blank_lz = 1'b1;
        check("rdy 64", 32'(load_ready), 32'h1);
        slot_check("lz0070", 16'h0070);
        step();
        load_valid = 1'b0;
        while (cyc < 80) begin
            check("one accept", 32'(load_ready), 32'h0);
            slot_check("lz0070", 16'h0070);
            step();
        end
        load_valid = 1'b1;
        load_data  = 16'h0000;
        check("rdy 80", 32'(load_ready), 32'h1);
        slot_check("lz0007", 16'h0007);
        step();
        load_valid = 1'b0;
        while (cyc < 96) begin
            slot_check("lz0007", 16'h0007);
            step();
        end
        while (cyc < 111) begin
            slot_check("lz0000", 16'h0000);
            step();
        end
        check("fe rdy", 32'(load_ready), 32'h1);
        load_valid = 1'b1;
        load_data  = 16'h5555;
        step();
        load_valid = 1'b0;
        while (cyc < 128) begin
            check("fe wait val", 32'(dig_val), 32'h0);
            check("fe wait rdy", 32'(load_ready), 32'h0);
            step();
        end
        check("fe commit val", 32'(dig_val), 32'h5);
        check("fe commit rdy", 32'(load_ready), 32'h1);
        load_valid = 1'b1;
        load_data  = 16'hBEEF;
        step();
        load_valid = 1'b0;
        step();
        check("pend before rst", 32'(load_ready), 32'h0);
        #2 rst = 1'b1;
        #1;
        check("arst en", 32'(dig_en), 32'hF);
        check("arst val", 32'(dig_val), 32'h0);
        check("arst rdy", 32'(load_ready), 32'h1);
        check("arst fs", 32'(frame_start), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0;
        blank_lz = 1'b0;
`ifdef HEX_SCAN_BLINK_EN
        bmask = 4'b0001;
`endif
        while (cyc < 96) begin
            check("post rst rdy", 32'(load_ready), 32'h1);
            slot_check("post rst", 16'h0);
            step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
